registers_bank: RTL and testbench

General-purpose register file for the MIPS decode (ID) stage. It has two combinational read ports (A/B) and one clocked write port. Register R0 is hard-wired to zero. The full register contents are exported on a flattened debug bus for the debug unit.

---
 rtl/registers_bank_pkg.sv | 22 ++
 rtl/registers_bank.sv | 84 ++++++++
 tb/tb_registers_bank.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/registers_bank_pkg.sv
// rtl/registers_bank_pkg.sv - shared constants and helpers for the ID-stage register file
//
// Purpose : default geometry of the register file, the index of the
//           hard-wired zero register, and a helper that decides whether a
//           write address may actually modify storage.
package registers_bank_pkg;

    // Default geometry (MIPS: 32 registers of 32 bits).
    localparam int DEFAULT_BANK_SIZE = 32;
    localparam int DEFAULT_REG_SIZE  = 32;

    // R0 is architecturally constant zero.
    localparam int R0_INDEX = 0;

    // A register index may be written only if it is not R0 and lies inside
    // the implemented bank. Addresses past the end of a non power-of-two
    // bank (e.g. 10..15 with 10 registers) fall through as no-ops.
    function automatic bit index_is_writable(input int index, input int bank_size);
        return (index != R0_INDEX) && (index < bank_size);
    endfunction

endpackage

// File: rtl/registers_bank.sv
// rtl/registers_bank.sv - MIPS ID-stage register file, 2 async read ports, 1 clocked write port
//
// Purpose : general-purpose register file. R0 reads as zero and ignores
//           writes; out-of-range addresses read zero and ignore writes.
//           Reads are combinational with no write-to-read bypass (the
//           forwarding unit resolves that hazard). The whole bank is
//           exported flattened for the debug unit.
//
// Ports   :
//   i_clk          - clock, writes on rising edge
//   i_reset        - asynchronous active-high reset, clears every register
//   i_write_enable - write strobe sampled on rising edge
//   i_addr_a       - read address, port A
//   i_addr_b       - read address, port B
//   i_addr_wr      - write address
//   i_bus_wr       - write data
//   o_bus_a        - contents of register i_addr_a
//   o_bus_b        - contents of register i_addr_b
//   o_bus_debug    - all registers, register k at [k*REGISTERS_SIZE +: REGISTERS_SIZE]
module registers_bank
    import registers_bank_pkg::*;
#(
    parameter int REGISTERS_BANK_SIZE = DEFAULT_BANK_SIZE,
    parameter int REGISTERS_SIZE      = DEFAULT_REG_SIZE,
    localparam int ADDR_W             = $clog2(REGISTERS_BANK_SIZE)
) (
    input  logic                                        i_clk,
    input  logic                                        i_reset,
    input  logic                                        i_write_enable,
    input  logic [ADDR_W-1:0]                           i_addr_a,
    input  logic [ADDR_W-1:0]                           i_addr_b,
    input  logic [ADDR_W-1:0]                           i_addr_wr,
    input  logic [REGISTERS_SIZE-1:0]                   i_bus_wr,
    output logic [REGISTERS_SIZE-1:0]                   o_bus_a,
    output logic [REGISTERS_SIZE-1:0]                   o_bus_b,
    output logic [REGISTERS_BANK_SIZE*REGISTERS_SIZE-1:0] o_bus_debug
);

    logic [REGISTERS_SIZE-1:0] regs [REGISTERS_BANK_SIZE];

    // Write decode is done by comparing against every implemented index
    // rather than indexing with i_addr_wr directly, so an address beyond
    // the bank never produces an out-of-bounds array write.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < REGISTERS_BANK_SIZE; k++) begin
                regs[k] <= '0;
            end
        end else if (i_write_enable) begin
            for (int k = 0; k < REGISTERS_BANK_SIZE; k++) begin
                if (index_is_writable(k, REGISTERS_BANK_SIZE) &&
                    (i_addr_wr == ADDR_W'(k))) begin
                    regs[k] <= i_bus_wr;
                end
            end
        end
    end

    // Read muxes: default to zero so R0 and unimplemented addresses read 0.
    always_comb begin
        o_bus_a = '0;
        o_bus_b = '0;
        for (int k = 0; k < REGISTERS_BANK_SIZE; k++) begin
            if (k != R0_INDEX) begin
                if (i_addr_a == ADDR_W'(k)) begin
                    o_bus_a = regs[k];
                end
                if (i_addr_b == ADDR_W'(k)) begin
                    o_bus_b = regs[k];
                end
            end
        end
    end

    // Debug export; slice 0 is forced to zero rather than trusting storage.
    for (genvar g = 0; g < REGISTERS_BANK_SIZE; g++) begin : g_debug
        if (g == R0_INDEX) begin : g_zero
            assign o_bus_debug[g*REGISTERS_SIZE +: REGISTERS_SIZE] = '0;
        end else begin : g_reg
            assign o_bus_debug[g*REGISTERS_SIZE +: REGISTERS_SIZE] = regs[g];
        end
    end

endmodule

// File: tb/tb_registers_bank.sv
// tb/tb_registers_bank.sv - directed self-checking bench for registers_bank
module tb_registers_bank;

    localparam int N  = 10;
    localparam int W  = 32;
    localparam int AW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic            we;
    logic [AW-1:0]   addr_a;
    logic [AW-1:0]   addr_b;
    logic [AW-1:0]   addr_wr;
    logic [W-1:0]    bus_wr;
    logic [W-1:0]    bus_a;
    logic [W-1:0]    bus_b;
    logic [N*W-1:0]  bus_debug;

    logic [W-1:0]    model [N];
    int              n_asserts = 0;
    int              n_fail    = 0;

    registers_bank #(
        .REGISTERS_BANK_SIZE(N),
        .REGISTERS_SIZE     (W)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_write_enable(we),
        .i_addr_a      (addr_a),
        .i_addr_b      (addr_b),
        .i_addr_wr     (addr_wr),
        .i_bus_wr      (bus_wr),
        .o_bus_a       (bus_a),
        .o_bus_b       (bus_b),
        .o_bus_debug   (bus_debug)
    );

    always #5 clk = ~clk;

    function automatic logic [N*W-1:0] model_debug();
        logic [N*W-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k*W +: W] = model[k];
        return v;
    endfunction

    task automatic chk32(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_dbg(input string tag, input logic [N*W-1:0] exp);
        n_asserts++;
        assert (bus_debug === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, bus_debug, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < N; k++) model[k] = '0;
    endtask

    // Drive a write after the falling edge, then let one rising edge store it.
    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        @(negedge clk);
        we = 1'b1; addr_wr = a; bus_wr = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        clear_model();
    endtask

    initial begin
        logic [W-1:0] v;
        rst = 1'b1; we = 1'b0; addr_a = '0; addr_b = '0; addr_wr = '0; bus_wr = '0;
        clear_model();

        // Reset state
        #3;
        chk_dbg("reset_debug", '0);
        addr_a = 4'd5; addr_b = 4'd9; #1;
        chk32("reset_a", bus_a, '0);
        chk32("reset_b", bus_b, '0);
        @(negedge clk); rst = 1'b0;

        // 1. write R5 then asynchronous reset mid-cycle
        do_write(4'd5, 32'hDEADBEEF);
        chk32("r5_written_a", bus_a, 32'hDEADBEEF);
        @(negedge clk); #2;
        rst = 1'b1; #1;
        chk_dbg("async_reset_debug", '0);
        addr_a = 4'd5; addr_b = 4'd5; #1;
        chk32("async_reset_a", bus_a, '0);
        chk32("async_reset_b", bus_b, '0);
        // reset wins over a write on the same edge
        we = 1'b1; addr_wr = 4'd2; bus_wr = 32'h11112222;
        @(posedge clk); #1;
        chk_dbg("reset_priority", '0);
        we = 1'b0;
        @(negedge clk); rst = 1'b0;
        clear_model();

        // 2. write sweep 0..9, then read 9..5 on A and 0..4 on B
        for (int i = 0; i < N; i++) begin
            v = $urandom;
            if (i != 0) model[i] = v;
            do_write(AW'(i), v);
        end
        chk_dbg("sweep_debug", model_debug());
        for (int j = 0; j < 5; j++) begin
            addr_a = AW'(N - 1 - j);
            addr_b = AW'(j);
            #1;
            chk32($sformatf("sweep_a_%0d", N - 1 - j), bus_a, model[N - 1 - j]);
            chk32($sformatf("sweep_b_%0d", j), bus_b, model[j]);
        end
        addr_a = 4'd6; addr_b = 4'd6; #1;
        chk32("same_addr_a", bus_a, model[6]);
        chk32("same_addr_b", bus_b, model[6]);

        // 3. R0 protection
        do_write(4'd0, 32'hFFFFFFFF);
        addr_a = 4'd0; #1;
        chk32("r0_read_a", bus_a, '0);
        chk32("r0_debug", bus_debug[W-1:0], '0);

        // 4. write-enable gating after a reset
        pulse_reset();
        chk_dbg("reset2_debug", '0);
        @(negedge clk);
        we = 1'b0; addr_wr = 4'd3; bus_wr = 32'h12345678;
        repeat (4) @(posedge clk);
        #1;
        addr_b = 4'd3; #1;
        chk32("we_gate_r3", bus_b, '0);
        chk_dbg("we_gate_debug", model_debug());

        // 5. write latency and combinational read
        @(negedge clk);
        addr_a = 4'd7;
        we = 1'b1; addr_wr = 4'd7; bus_wr = 32'hCAFEF00D;
        #1;
        chk32("pre_edge_old", bus_a, '0);
        @(posedge clk); #1;
        we = 1'b0;
        model[7] = 32'hCAFEF00D;
        chk32("post_edge_new", bus_a, 32'hCAFEF00D);
        addr_a = 4'd3; #1;
        chk32("comb_read_r3", bus_a, '0);
        addr_a = 4'd7; #1;
        chk32("comb_read_r7", bus_a, 32'hCAFEF00D);

        // 6. out-of-range address
        do_write(4'd12, 32'hA5A5A5A5);
        chk_dbg("oor_debug", model_debug());
        addr_b = 4'd12; #1;
        chk32("oor_read_b", bus_b, '0);
        addr_a = 4'd15; #1;
        chk32("oor_read_a", bus_a, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
